// File: rtl/hilo_unit_pkg.sv
// Shared constants for the EX-stage HI/LO unit: op-bit indices, divide FSM
// encoding and the quotient/remainder split of the divider result.
package hilo_unit_pkg;

  // One-hot ex_op bit positions
  localparam int unsigned OP_MULT  = 0;
  localparam int unsigned OP_MULTU = 1;
  localparam int unsigned OP_DIV   = 2;
  localparam int unsigned OP_DIVU  = 3;
  localparam int unsigned OP_MTHI  = 4;
  localparam int unsigned OP_MTLO  = 5;
  localparam int unsigned OP_MFHI  = 6;
  localparam int unsigned OP_MFLO  = 7;

  // Divider result layout: quotient in the upper word, remainder in the lower
  localparam int unsigned QUOT_MSB = 63;
  localparam int unsigned QUOT_LSB = 32;
  localparam int unsigned REM_MSB  = 31;
  localparam int unsigned REM_LSB  = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StDone  = 2'd2,
    StDrain = 2'd3
  } div_state_e;

endpackage

// File: rtl/hilo_unit.sv
// EX-stage HI/LO register unit: commits multiply/divide results and mthi/mtlo
// writes, serves mfhi/mflo, and stalls EX while a divide is outstanding.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [7:0]       ex_op,
  input  logic [31:0]      ex_rs_value,
  input  logic             ex_cancel,
  input  logic             ex_allowin,
  input  logic [63:0]      alu_result,
  input  logic             div_done,
  output logic             ex_ready_go,
  output logic             div_start,
  output logic [31:0]      rd_value,
  output logic [31:0]      hi_q,
  output logic [31:0]      lo_q,
  output logic [CNT_W-1:0] div_cycles_last
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      buf_q, buf_d;
  // Set when the outstanding divider result already arrived with the cancel,
  // so DRAIN has nothing left to wait for.
  logic             drop_q, drop_d;
  logic [31:0]      hi_d, lo_d;
  logic [CNT_W-1:0] div_cycles_q, div_cycles_d;

  logic is_div;
  logic is_mul;
  logic div_req;
  logic fire;

  assign is_div  = ex_op[OP_DIV] | ex_op[OP_DIVU];
  assign is_mul  = ex_op[OP_MULT] | ex_op[OP_MULTU];
  assign div_req = ex_valid & is_div & ~ex_cancel;
  assign fire    = ex_valid & ~ex_cancel & ex_ready_go & ex_allowin;

  assign div_cycles_last = div_cycles_q;

  // Move-from reads straight off the architectural registers
  always_comb begin
    rd_value = 32'd0;
    if (ex_op[OP_MFHI]) begin
      rd_value = hi_q;
    end else if (ex_op[OP_MFLO]) begin
      rd_value = lo_q;
    end
  end

  // Stall and divide-issue decode from the current FSM state
  always_comb begin
    ex_ready_go = 1'b1;
    div_start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (div_req) begin
          ex_ready_go = 1'b0;
          div_start   = 1'b1;
        end
      end
      StWait:  ex_ready_go = 1'b0;
      StDone:  ex_ready_go = 1'b1;
      // A younger divide must wait until the cancelled one has drained
      StDrain: ex_ready_go = ~(ex_valid & is_div);
      default: ex_ready_go = 1'b1;
    endcase
  end

  // Divide FSM next state, latency counter and result buffer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    drop_d  = drop_q;
    unique case (state_q)
      StIdle: begin
        if (div_req) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
        if (div_done && ex_cancel) begin
          drop_d  = 1'b1;
          state_d = StDrain;
        end else if (div_done) begin
          buf_d   = alu_result;
          state_d = StDone;
        end else if (ex_cancel) begin
          drop_d  = 1'b0;
          state_d = StDrain;
        end
      end
      StDone: begin
        if (ex_cancel) begin
          buf_d   = '0;
          state_d = StIdle;
        end else if (fire) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        // Divider cannot be aborted: swallow its result, then return to idle
        if (drop_q || div_done) begin
          drop_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // HI/LO commit and last-divide latency capture
  always_comb begin
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_cycles_d = div_cycles_q;
    if (fire) begin
      if (state_q == StDone) begin
        lo_d         = buf_q[QUOT_MSB:QUOT_LSB];
        hi_d         = buf_q[REM_MSB:REM_LSB];
        div_cycles_d = cnt_q;
      end else begin
        if (is_mul) begin
          hi_d = alu_result[63:32];
          lo_d = alu_result[31:0];
        end
        if (ex_op[OP_MTHI]) begin
          hi_d = ex_rs_value;
        end
        if (ex_op[OP_MTLO]) begin
          lo_d = ex_rs_value;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      buf_q        <= '0;
      drop_q       <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      div_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      drop_q       <= drop_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      div_cycles_q <= div_cycles_d;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [7:0]  ex_op;
  logic [31:0] ex_rs_value;
  logic        ex_cancel;
  logic        ex_allowin;
  logic [63:0] alu_result;
  logic        div_done;
  logic        ex_ready_go;
  logic        div_start;
  logic [31:0] rd_value;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [15:0] div_cycles_last;

  int checks = 0;
  int errors = 0;

  hilo_unit #(.CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_op           (ex_op),
    .ex_rs_value     (ex_rs_value),
    .ex_cancel       (ex_cancel),
    .ex_allowin      (ex_allowin),
    .alu_result      (alu_result),
    .div_done        (div_done),
    .ex_ready_go     (ex_ready_go),
    .div_start       (div_start),
    .rd_value        (rd_value),
    .hi_q            (hi_q),
    .lo_q            (lo_q),
    .div_cycles_last (div_cycles_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    check({tag, ".hi"}, 64'(hi_q), 64'(hi));
    check({tag, ".lo"}, 64'(lo_q), 64'(lo));
  endtask

  initial begin
    reset       = 1'b1;
    ex_valid    = 1'b0;
    ex_op       = 8'h00;
    ex_rs_value = 32'd0;
    ex_cancel   = 1'b0;
    ex_allowin  = 1'b1;
    alu_result  = 64'd0;
    div_done    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_regs("reset", 32'h0, 32'h0);
    check("reset.dcl", 64'(div_cycles_last), 64'd0);
    check("reset.ready_go", 64'(ex_ready_go), 64'd1);
    check("reset.div_start", 64'(div_start), 64'd0);

    // mult -3 * 5
    tick();
    ex_valid   = 1'b1;
    ex_op      = 8'h01;
    alu_result = 64'hFFFF_FFFF_FFFF_FFF1;
    #1;
    check("mult.ready_go", 64'(ex_ready_go), 64'd1);
    tick();
    ex_valid   = 1'b0;
    alu_result = 64'd0;
    #1;
    check_regs("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // divu 100/7: done 8 cycles after start, stall 9 cycles
    tick();
    ex_valid = 1'b1;
    ex_op    = 8'h08;
    for (int i = 0; i <= 8; i++) begin
      div_done   = (i == 8);
      alu_result = (i == 8) ? {32'd14, 32'd2} : 64'hAAAA_AAAA_AAAA_AAAA;
      #1;
      check($sformatf("divu.stall%0d", i), 64'(ex_ready_go), 64'd0);
      check($sformatf("divu.start%0d", i), 64'(div_start), 64'((i == 0) ? 1 : 0));
      tick();
    end
    div_done   = 1'b0;
    alu_result = 64'h5555_5555_5555_5555;
    #1;
    check("divu.done_ready", 64'(ex_ready_go), 64'd1);
    check_regs("divu.before", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    tick();
    ex_valid = 1'b0;
    #1;
    check_regs("divu", 32'd2, 32'd14);
    check("divu.dcl", 64'(div_cycles_last), 64'd8);

    // div held in DONE by allowin=0 for 3 cycles
    tick();
    ex_valid = 1'b1;
    ex_op    = 8'h04;
    for (int i = 0; i <= 2; i++) begin
      div_done   = (i == 2);
      alu_result = (i == 2) ? {32'd3, 32'd1} : 64'd0;
      tick();
    end
    div_done   = 1'b0;
    alu_result = 64'd0;
    ex_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold%0d.ready_go", i), 64'(ex_ready_go), 64'd1);
      check_regs($sformatf("hold%0d", i), 32'd2, 32'd14);
      tick();
    end
    ex_allowin = 1'b1;
    tick();
    ex_valid = 1'b0;
    #1;
    check_regs("hold.commit", 32'd1, 32'd3);
    check("hold.dcl", 64'(div_cycles_last), 64'd2);
    tick();
    #1;
    check_regs("hold.once", 32'd1, 32'd3);

    // div cancelled 2 cycles into WAIT, younger divu waits for the drain
    ex_valid = 1'b1;
    ex_op    = 8'h04;
    #1;
    check("cxl.start", 64'(div_start), 64'd1);
    tick();
    tick();
    ex_cancel = 1'b1;
    tick();
    ex_cancel = 1'b0;
    ex_op     = 8'h08;
    for (int i = 0; i < 3; i++) begin
      div_done   = (i == 2);
      alu_result = (i == 2) ? 64'h0000_0BAD_0000_0BAD : 64'd0;
      #1;
      check($sformatf("drain%0d.start", i), 64'(div_start), 64'd0);
      check($sformatf("drain%0d.ready", i), 64'(ex_ready_go), 64'd0);
      tick();
    end
    div_done   = 1'b0;
    alu_result = 64'd0;
    for (int i = 0; i <= 4; i++) begin
      div_done   = (i == 4);
      alu_result = (i == 4) ? {32'd20, 32'd5} : 64'd0;
      #1;
      check($sformatf("redo%0d.start", i), 64'(div_start), 64'((i == 0) ? 1 : 0));
      check_regs($sformatf("redo%0d", i), 32'd1, 32'd3);
      tick();
    end
    div_done   = 1'b0;
    alu_result = 64'd0;
    tick();
    ex_valid = 1'b0;
    #1;
    check_regs("redo", 32'd5, 32'd20);
    check("redo.dcl", 64'(div_cycles_last), 64'd4);

    // cancel and div_done together: one DRAIN cycle, then idle
    tick();
    ex_valid = 1'b1;
    ex_op    = 8'h04;
    tick();
    ex_cancel  = 1'b1;
    div_done   = 1'b1;
    alu_result = 64'h1111_1111_2222_2222;
    tick();
    ex_cancel  = 1'b0;
    div_done   = 1'b0;
    alu_result = 64'd0;
    #1;
    check("both.drain_start", 64'(div_start), 64'd0);
    tick();
    #1;
    check("both.idle_start", 64'(div_start), 64'd1);
    check_regs("both", 32'd5, 32'd20);
    ex_valid = 1'b0;
    // the restarted divide is abandoned below by reset

    // mthi / mtlo / mfhi / mflo
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    ex_valid    = 1'b1;
    ex_op       = 8'h10;
    ex_rs_value = 32'hDEAD_BEEF;
    tick();
    ex_op       = 8'h20;
    ex_rs_value = 32'h1234_5678;
    tick();
    ex_op       = 8'h40;
    ex_rs_value = 32'd0;
    #1;
    check("mfhi", 64'(rd_value), 64'(32'hDEAD_BEEF));
    tick();
    ex_op = 8'h80;
    #1;
    check("mflo", 64'(rd_value), 64'(32'h1234_5678));
    check_regs("mt", 32'hDEAD_BEEF, 32'h1234_5678);
    tick();
    ex_op = 8'h01;
    #1;
    check("rd_none", 64'(rd_value), 64'd0);
    ex_valid = 1'b0;

    // reset while in WAIT, then a stale div_done
    tick();
    ex_valid = 1'b1;
    ex_op    = 8'h04;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    ex_valid   = 1'b0;
    div_done   = 1'b1;
    alu_result = 64'h0000_0001_0000_0001;
    #1;
    check("rst.ready_go", 64'(ex_ready_go), 64'd1);
    tick();
    div_done   = 1'b0;
    alu_result = 64'd0;
    #1;
    check_regs("rst", 32'h0, 32'h0);
    check("rst.dcl", 64'(div_cycles_last), 64'd0);
    ex_valid = 1'b1;
    ex_op    = 8'h08;
    #1;
    check("rst.idle_start", 64'(div_start), 64'd1);
    ex_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Execute-stage HI/LO register unit that consumes the ALU's 64-bit multiply/divide results and commits them to the architectural HI and LO registers.
- Owns the divide wait sequencing: it holds the EX stage until the divider result arrives, drains cancelled divides, and serves mfhi/mflo/mthi/mtlo.
- Sits beside the ALU in EX. Its outputs feed the EX→MEM pipeline register and the stage's ready_go logic.

Parameters:
- CNT_W, 16, width of the saturating divide-latency counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_op  in  8  one-hot op: [0] mult, [1] multu, [2] div, [3] divu, [4] mthi, [5] mtlo, [6] mfhi, [7] mflo
- ex_rs_value  in  32  rs operand for mthi/mtlo
- ex_cancel  in  1  flush/exception kills the EX instruction this cycle
- ex_allowin  in  1  downstream (MEM) accepts the EX instruction this cycle
- alu_result  in  64  ALU 64-bit result
- div_done  in  1  divider result valid pulse from the ALU
- ex_ready_go  out  1  EX instruction may leave this cycle
- div_start  out  1  a divide is issued to the ALU this cycle
- rd_value  out  32  HI (mfhi) or LO (mflo), else 0
- hi_q  out  32  architectural HI
- lo_q  out  32  architectural LO
- div_cycles_last  out  CNT_W  cycles spent in WAIT by the last committed divide

Behaviour:
- Reset state: hi_q=0, lo_q=0, state=IDLE, div_cycles_last=0, internal counter=0, result buffer=0. Outputs after reset: ex_ready_go=1, div_start=0.
- Definitions:
  - fire = ex_valid & ~ex_cancel & ex_ready_go & ex_allowin
  - is_div = ex_op[2] | ex_op[3]
- Multiply (mult/multu):
  - ex_ready_go=1.
  - On fire: hi_q<=alu_result[63:32], lo_q<=alu_result[31:0].
  - Latency 0; the register update is visible the next cycle.
- mthi / mtlo: on fire, write ex_rs_value into hi_q or lo_q respectively. The other register is unchanged.
- mfhi / mflo:
  - rd_value is combinational from current hi_q/lo_q; ex_ready_go=1.
  - Commits occur only at clock edges, so no forwarding path is needed.
  - An older instruction has always committed before a younger one reaches EX.
- Divide FSM, states IDLE, WAIT, DONE, DRAIN:
  - IDLE:
    - ex_valid & is_div & ~ex_cancel: div_start=1, ex_ready_go=0, counter<=0, next state WAIT.
    - Non-divide ops proceed per the rules above.
  - WAIT:
    - ex_ready_go=0 and the counter increments (saturates at 2^CNT_W-1).
    - On div_done: buffer<=alu_result, next state DONE.
    - On ex_cancel without div_done: next state DRAIN.
    - ex_cancel and div_done in the same cycle: go to DRAIN, then immediately to IDLE next cycle (result discarded).
  - DONE:
    - ex_ready_go=1.
    - On fire: lo_q<=buffer[63:32] (quotient), hi_q<=buffer[31:0] (remainder), div_cycles_last<=counter, next state IDLE.
    - On ex_cancel: discard buffer, next state IDLE.
    - ~ex_allowin: hold DONE.
  - DRAIN:
    - The divider cannot be aborted, so this state waits for div_done and drops the result; no HI/LO write occurs. Then next state IDLE.
    - A new divide in EX sees ex_ready_go=0 and div_start=0 until the state returns to IDLE, then it starts normally.
    - Non-divide ops proceed.
- div_start is asserted only in IDLE, at most once per divide instruction.
- Divide commit latency is divider latency + 1 cycle (DONE).
- Divide by zero: whatever the divider produces is committed; no trap.
- Illegal ex_op (more than one bit set): undefined; the bench never drives it.
- ex_valid=0 or ex_op=0: ex_ready_go=1, no state change in IDLE.
- Reset mid-divide: state returns to IDLE and HI/LO clear. A late div_done after reset is ignored in IDLE.

Decomposition:
- Shared package holds:
  - op-bit index constants (OP_MULT..OP_MFLO)
  - FSM state encoding
  - the div-result field split constants (quotient [63:32], remainder [31:0]).
- Single flat module; no sub-module is warranted.

Test Plan:
- mult -3 × 5 (alu_result=64'hFFFFFFFF_FFFFFFF1), ex_allowin=1 → hi_q=FFFFFFFF, lo_q=FFFFFFF1 next cycle; ex_ready_go stays 1.
- divu 100/7, div_done 8 cycles after div_start with alu_result={32'd14, 32'd2} → ex_ready_go=0 for 9 cycles, then lo_q=14, hi_q=2, div_cycles_last=8.
- div in DONE with ex_allowin=0 for 3 cycles → HI/LO unchanged until allowin=1, then commit once.
- div cancelled 2 cycles into WAIT, followed immediately by a new divu → new divu stalls with div_start=0 until the old div_done. HI/LO never reflect the cancelled result. The new divu then starts and commits correctly.
- mthi 0xDEADBEEF, then mtlo 0x12345678, then mfhi and mflo back to back → rd_value=DEADBEEF, then 12345678.
- Assert reset while in WAIT, then pulse div_done → state IDLE, hi_q=lo_q=0, no write from the stale div_done.
